arb_req_fifo: RTL and testbench
===============================

Name: arb_req_fifo

Overview:
- Request-ordering queue for the PCI arbiter in first-in-first-out mode.
- Samples the eight active-low REQ# lines and records each newly requesting master in arrival order.
- Presents the head entry as a one-hot-low 8-bit word; this word feeds directly into the arbiter's grant decoder.
- The arbiter pops the head when the granted master's transaction completes.

Parameters:
- N_REQ, 8: number of bus masters and width of the REQ#/head words. Fixed at 8 to match the grant decoder.
- DEPTH, 8: number of queue entries. Must be >= N_REQ; elaboration fails otherwise.
- IDX_W, 3: width of a stored master index, equal to clog2(N_REQ).

Ports:
- clk  in  1  PCI clock; all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_n  in  8  PCI REQ# lines, active low, synchronous to clk. Bit i belongs to master i.
- pop  in  1  one-cycle pulse from the arbiter: retire the head entry.
- head_n  out  8  one-hot-low index of the head master. 8'hFF when the queue is empty.
- empty  out  1  high when count == 0.
- count  out  4  number of valid entries, 0..DEPTH.
- queued  out  8  bit i high while master i holds an entry.

Behaviour:
- Reset: asynchronous and active-low; takes effect immediately, even mid-operation. Required values while reset is asserted:
  - req_q = 8'hFF; wr_ptr, rd_ptr, count = 0; queued = 0.
  - head_n = 8'hFF, empty = 1.
  - All queued entries are discarded.
- Input stage: req_n is registered once into req_q. Define active[i] = ~req_q[i].
- Enqueue candidate: cand = active & ~queued.
  - If cand != 0, exactly one master enqueues per cycle: the lowest set index.
  - Enqueue writes its index to mem[wr_ptr], increments wr_ptr modulo DEPTH and sets queued[i].
  - Other candidates remain candidates and enqueue on following cycles in ascending index order.
- Latency: REQ# low sampled at edge k, enqueued at edge k+1. If the queue was empty, head_n shows the master after edge k+1.
- Pop: pop && !empty retires the head:
  - rd_ptr increments modulo DEPTH.
  - queued bit of the head index clears.
  - pop while empty is ignored with no state change.
- Simultaneous pop and enqueue: both take effect in the same cycle, so count is unchanged.
- Pop with continued REQ#: the popped master's queued bit is still 1 during the pop cycle, so it cannot re-enqueue that cycle. If its REQ# is still low, it re-enqueues at the tail on the next cycle (round-robin-like fairness).
- Duplicates: a master is never stored twice; queued[i] blocks this.
- Overflow: impossible. At most N_REQ <= DEPTH distinct entries can exist, and no full flag is required.
- Stale entries: a master that deasserts REQ# while queued keeps its entry. Only pop removes an entry, because a master legitimately drops REQ# during its own transaction.
- Pointers wrap modulo DEPTH. count = entries written minus entries popped.
- head_n = empty ? 8'hFF : ~(8'b1 << mem[rd_ptr]). It is combinational from registered state and glitch-free after each edge. The decoder maps 8'hFF to high-Z.

Decomposition:
- Shared package arb_pkg:
  - N_REQ = 8.
  - IDX_W = 3.
  - REQ_IDLE_N = 8'hFF.
  - Index type logic [IDX_W-1:0].
- One sub-module: lowest_bit_enc (N_REQ-bit vector in; valid flag and index of lowest set bit out). Selects the enqueue candidate.
- Storage and pointers stay inline.

Test Plan:
- Reset behaviour: assert rst_n=0 with req_n=8'h00 -> head_n=8'hFF, empty=1, count=0, queued=0. Release -> masters 0..7 enqueue on 8 consecutive cycles, count reaches 8.
- Single request: req_n=8'hFB from cycle 0 -> head_n=8'hFB and count=1 after edge 2. pop pulse plus req_n=8'hFF -> head_n=8'hFF, empty=1.
- Arrival order: master 5 at t0, master 1 at t2, master 6 at t4, all held low -> head_n=8'hDF, then after pops 8'hFD, then 8'hBF.
- Simultaneous requests: req_n=8'h6E (masters 0,4,7) in one cycle -> index 0, 4, 7 enqueued on three successive cycles. Popping yields 8'hFE, 8'hEF, 8'h7F.
- Pop with enqueue, and pop with held REQ#:
  - Count=2 (heads 2,3); pop in the same cycle master 6 first appears in req_q -> count stays 2, queue becomes 3,6.
  - Master 3 holds REQ# low through its pop -> queued[3] drops for one cycle, then master 3 reappears at the tail.
- Reset mid-operation and pop-when-empty:
  - With count=5, drop rst_n between edges -> head_n=8'hFF immediately, count=0.
  - pop while empty -> no change.

Source files
------------

// File: rtl/arb_pkg.sv
// Shared types and constants for the PCI arbiter request-ordering queue.
package arb_pkg;

  localparam int N_REQ = 8;
  localparam int IDX_W = 3;
  localparam logic [N_REQ-1:0] REQ_IDLE_N = 8'hFF;

  typedef logic [IDX_W-1:0] idx_t;

  // Expand a master index into a one-hot (active-high) vector.
  function automatic logic [N_REQ-1:0] idx_to_onehot(input idx_t idx);
    logic [N_REQ-1:0] one;
    one = {{(N_REQ-1){1'b0}}, 1'b1};
    return one << idx;
  endfunction

endpackage

// File: rtl/lowest_bit_enc.sv
// Finds the lowest set bit of a request vector; used to pick the next master to enqueue.
module lowest_bit_enc
  import arb_pkg::*;
(
  input  logic [N_REQ-1:0] vec,
  output logic             valid,
  output idx_t             idx
);

  // Scan from the top down so the lowest set index is the last one to win.
  always_comb begin
    valid = |vec;
    idx   = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (vec[i]) begin
        idx = IDX_W'(i);
      end else begin
        idx = idx;
      end
    end
  end

endmodule

// File: rtl/arb_req_fifo.sv
// FIFO of requesting masters in arrival order; head presented one-hot-low to the grant decoder.
module arb_req_fifo
  import arb_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_REQ-1:0] req_n,
  input  logic             pop,
  output logic [N_REQ-1:0] head_n,
  output logic             empty,
  output logic [3:0]       count,
  output logic [N_REQ-1:0] queued
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  if (DEPTH < N_REQ || DEPTH > 15) begin : g_depth_chk
    $error("arb_req_fifo: DEPTH must be in N_REQ..15");
  end

  logic [N_REQ-1:0] req_q_r;
  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [3:0]       count_r;
  logic [N_REQ-1:0] queued_r;
  idx_t             mem_r [DEPTH];

  logic [N_REQ-1:0] cand_s;
  logic             push_s;
  logic             do_pop_s;
  idx_t             push_idx_s;
  idx_t             head_idx_s;
  logic             empty_s;

  assign cand_s     = ~req_q_r & ~queued_r;
  assign empty_s    = (count_r == 4'd0);
  assign do_pop_s   = pop & ~empty_s;
  assign head_idx_s = mem_r[rd_ptr_r];

  lowest_bit_enc u_enc (
    .vec   (cand_s),
    .valid (push_s),
    .idx   (push_idx_s)
  );

  // Input register, pointers, occupancy and storage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_q_r  <= REQ_IDLE_N;
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= 4'd0;
      queued_r <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= '0;
      end
    end else begin
      req_q_r <= req_n;
      if (push_s) begin
        mem_r[wr_ptr_r] <= push_idx_s;
        wr_ptr_r <= (wr_ptr_r == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr_r + 1'b1;
      end else begin
        wr_ptr_r <= wr_ptr_r;
      end
      if (do_pop_s) begin
        rd_ptr_r <= (rd_ptr_r == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr_r + 1'b1;
      end else begin
        rd_ptr_r <= rd_ptr_r;
      end
      // A popped head is still queued this cycle, so it can never collide with the pushed index.
      queued_r <= (queued_r | (push_s ? idx_to_onehot(push_idx_s) : '0))
                & ~(do_pop_s ? idx_to_onehot(head_idx_s) : '0);
      case ({push_s, do_pop_s})
        2'b10:   count_r <= count_r + 4'd1;
        2'b01:   count_r <= count_r - 4'd1;
        default: count_r <= count_r;
      endcase
    end
  end

  // Head decode straight from registered state.
  always_comb begin
    if (empty_s) begin
      head_n = REQ_IDLE_N;
    end else begin
      head_n = ~idx_to_onehot(head_idx_s);
    end
  end

  assign empty  = empty_s;
  assign count  = count_r;
  assign queued = queued_r;

endmodule

// File: tb/tb_arb_req_fifo.sv
// Directed bench for arb_req_fifo with hand-computed expectations.
module tb_arb_req_fifo;

  logic       clk;
  logic       rst_n;
  logic [7:0] req_n;
  logic       pop;
  logic [7:0] head_n;
  logic       empty;
  logic [3:0] count;
  logic [7:0] queued;

  int n_vec = 0;
  int n_err = 0;

  arb_req_fifo dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .req_n  (req_n),
    .pop    (pop),
    .head_n (head_n),
    .empty  (empty),
    .count  (count),
    .queued (queued)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_vec(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset(input logic [7:0] r);
    rst_n = 1'b0;
    req_n = r;
    pop   = 1'b0;
    step(2);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    req_n = 8'h00;
    pop   = 1'b0;
    step(2);
    check_vec("rst_head", head_n, 8'hFF);
    check_vec("rst_empty", {7'd0, empty}, 8'h01);
    check_vec("rst_count", {4'd0, count}, 8'h00);
    check_vec("rst_queued", queued, 8'h00);

    // All eight request at once: one enqueue per cycle, lowest first.
    rst_n = 1'b1;
    step(1);
    check_vec("all_cnt0", {4'd0, count}, 8'h00);
    for (int i = 1; i <= 8; i++) begin
      step(1);
      check_vec("all_cnt", {4'd0, count}, 8'(i));
      check_vec("all_head", head_n, 8'hFE);
    end
    check_vec("all_queued", queued, 8'hFF);

    // Single request then pop.
    do_reset(8'hFF);
    req_n = 8'hFB;
    step(1);
    check_vec("single_lat", head_n, 8'hFF);
    step(1);
    check_vec("single_head", head_n, 8'hFB);
    check_vec("single_cnt", {4'd0, count}, 8'h01);
    pop = 1'b1;
    req_n = 8'hFF;
    step(1);
    pop = 1'b0;
    check_vec("single_pop_head", head_n, 8'hFF);
    check_vec("single_pop_empty", {7'd0, empty}, 8'h01);
    step(1);
    check_vec("single_stay_empty", {4'd0, count}, 8'h00);

    // Arrival order 5, 1, 6; held requests re-enqueue at tail after pop.
    do_reset(8'hFF);
    req_n = 8'hDF;
    step(2);
    req_n = 8'hDD;
    step(2);
    req_n = 8'h9D;
    step(2);
    check_vec("order_head0", head_n, 8'hDF);
    check_vec("order_cnt", {4'd0, count}, 8'h03);
    pop = 1'b1;
    step(1);
    check_vec("order_head1", head_n, 8'hFD);
    check_vec("order_cnt1", {4'd0, count}, 8'h02);
    step(1);
    pop = 1'b0;
    check_vec("order_head2", head_n, 8'hBF);
    check_vec("order_cnt2", {4'd0, count}, 8'h02);
    check_vec("order_queued", queued, 8'h60);

    // Simultaneous requests 0, 4, 7.
    do_reset(8'hFF);
    req_n = 8'h6E;
    step(2);
    check_vec("sim_head", head_n, 8'hFE);
    check_vec("sim_cnt1", {4'd0, count}, 8'h01);
    step(2);
    check_vec("sim_cnt3", {4'd0, count}, 8'h03);
    check_vec("sim_queued", queued, 8'h91);
    req_n = 8'hFF;
    pop = 1'b1;
    step(1);
    check_vec("sim_pop1", head_n, 8'hEF);
    step(1);
    check_vec("sim_pop2", head_n, 8'h7F);
    step(1);
    pop = 1'b0;
    check_vec("sim_pop3", head_n, 8'hFF);
    check_vec("sim_empty", {7'd0, empty}, 8'h01);

    // Pop with simultaneous enqueue, then pop with held REQ#.
    do_reset(8'hFF);
    req_n = 8'hF3;
    step(2);
    req_n = 8'hB3;
    step(1);
    check_vec("pe_cnt", {4'd0, count}, 8'h02);
    check_vec("pe_head", head_n, 8'hFB);
    req_n = 8'hB7;
    pop = 1'b1;
    step(1);
    check_vec("pe_cnt_same", {4'd0, count}, 8'h02);
    check_vec("pe_head3", head_n, 8'hF7);
    check_vec("pe_queued", queued, 8'h48);
    step(1);
    pop = 1'b0;
    check_vec("hold_cnt", {4'd0, count}, 8'h01);
    check_vec("hold_drop", queued, 8'h40);
    check_vec("hold_head6", head_n, 8'hBF);
    step(1);
    check_vec("hold_requeue", queued, 8'h48);
    check_vec("hold_cnt2", {4'd0, count}, 8'h02);
    pop = 1'b1;
    step(1);
    pop = 1'b0;
    check_vec("hold_tail", head_n, 8'hF7);

    // Reset mid-operation, then pop while empty.
    do_reset(8'hFF);
    req_n = 8'hE0;
    step(6);
    check_vec("mid_cnt5", {4'd0, count}, 8'h05);
    #3;
    rst_n = 1'b0;
    #1;
    check_vec("mid_head", head_n, 8'hFF);
    check_vec("mid_cnt", {4'd0, count}, 8'h00);
    check_vec("mid_empty", {7'd0, empty}, 8'h01);
    check_vec("mid_queued", queued, 8'h00);
    req_n = 8'hFF;
    step(1);
    rst_n = 1'b1;
    pop = 1'b1;
    step(2);
    pop = 1'b0;
    check_vec("pe_empty_cnt", {4'd0, count}, 8'h00);
    check_vec("pe_empty_head", head_n, 8'hFF);
    check_vec("pe_empty_q", queued, 8'h00);
    // Pointers must be untouched: a fresh request lands at the head.
    req_n = 8'h7F;
    step(2);
    check_vec("pe_after_head", head_n, 8'h7F);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
